// File: rtl/nodf_mon_pkg.sv
// nodf_mon_pkg: shared state encoding and saturation helper for the
// non-dataflow block handshake monitor.
package nodf_mon_pkg;

    localparam int unsigned STATE_W   = 2;
    localparam int unsigned SAT_W_MAX = 64;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 2'd0,
        ST_BUSY      = 2'd1,
        ST_DONE_WAIT = 2'd2,
        ST_FINISHED  = 2'd3
    } mon_state_e;

    // All-ones value of a width-bit counter, right-aligned in a 64-bit word.
    function automatic logic [SAT_W_MAX-1:0] SAT_MAX(input int unsigned width);
        logic [SAT_W_MAX-1:0] ones;
        ones = '1;
        if (width >= SAT_W_MAX) begin
            return ones;
        end
        return ones >> (SAT_W_MAX - width);
    endfunction

endpackage

// File: rtl/nodf_module_intf_sat_counter.sv
// sat_counter: CNT_W-bit up-counter that sticks at all-ones.
// clr with en loads 1 (first counted cycle); clr alone loads 0.
module sat_counter
    import nodf_mon_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAT_MAX(CNT_W));

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = en ? CNT_W'(1) : '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/nodf_module_intf.sv
// nodf_module_intf: passive monitor of one HLS block's ap_* handshake.
// Define NODF_MONITOR_MINMAX_EN to add min_latency/max_latency tracking.
module nodf_module_intf
    import nodf_mon_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ap_start,
    input  logic               ap_ready,
    input  logic               ap_done,
    input  logic               ap_continue,
    input  logic               finish,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   txn_count,
    output logic [CNT_W-1:0]   last_latency,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic               sample_valid,
    output logic               proto_err,
`ifdef NODF_MONITOR_MINMAX_EN
    output logic [CNT_W-1:0]   min_latency,
    output logic [CNT_W-1:0]   max_latency,
`endif
    output logic               finished
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAT_MAX(CNT_W));

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] last_latency_q, last_latency_d;
    logic             sample_valid_q, sample_valid_d;
    logic             proto_err_q, proto_err_d;
    logic             finished_q, finished_d;

    logic             lat_clr_c, lat_en_c, txn_en_c, stall_en_c, complete_c;
    logic [CNT_W-1:0] lat_cnt_c, lat_done_c;

    sat_counter #(.CNT_W(CNT_W)) u_lat_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (lat_clr_c),
        .en    (lat_en_c),
        .q     (lat_cnt_c)
    );

    sat_counter #(.CNT_W(CNT_W)) u_txn_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (1'b0),
        .en    (txn_en_c),
        .q     (txn_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (1'b0),
        .en    (stall_en_c),
        .q     (stall_cycles)
    );

    // Latency including the completing cycle; a same-cycle start/done is 1.
    always_comb begin
        lat_done_c = CNT_W'(1);
        if (state_q != ST_IDLE) begin
            lat_done_c = (lat_cnt_c == CNT_MAX) ? lat_cnt_c : lat_cnt_c + CNT_W'(1);
        end
    end

    always_comb begin
        state_d        = state_q;
        last_latency_d = last_latency_q;
        sample_valid_d = 1'b0;
        proto_err_d    = proto_err_q;
        finished_d     = finished_q;
        lat_clr_c      = 1'b0;
        lat_en_c       = 1'b0;
        txn_en_c       = 1'b0;
        stall_en_c     = 1'b0;
        complete_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    lat_clr_c = 1'b1;
                    lat_en_c  = 1'b1;
                    if (ap_done && ap_continue) begin
                        complete_c = 1'b1;
                    end else begin
                        state_d    = ST_BUSY;
                        stall_en_c = ap_done;
                    end
                end else if (ap_ready || ap_done) begin
                    proto_err_d = 1'b1;
                end
            end
            ST_BUSY: begin
                lat_en_c = 1'b1;
                if (ap_done && ap_continue) begin
                    complete_c = 1'b1;
                    state_d    = ST_IDLE;
                end else if (ap_done) begin
                    stall_en_c = 1'b1;
                    state_d    = ST_DONE_WAIT;
                end
            end
            ST_DONE_WAIT: begin
                lat_en_c = 1'b1;
                if (ap_continue) begin
                    complete_c = 1'b1;
                    state_d    = ST_IDLE;
                end else if (ap_done) begin
                    stall_en_c = 1'b1;
                end else begin
                    // done withdrawn before acknowledge: transaction is dropped
                    proto_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_FINISHED: begin
                state_d = ST_FINISHED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (complete_c) begin
            txn_en_c       = 1'b1;
            last_latency_d = lat_done_c;
            sample_valid_d = 1'b1;
        end

        // A completion coinciding with finish is still recorded above.
        if (finish) begin
            state_d    = ST_FINISHED;
            finished_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            last_latency_q <= '0;
            sample_valid_q <= 1'b0;
            proto_err_q    <= 1'b0;
            finished_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_latency_q <= last_latency_d;
            sample_valid_q <= sample_valid_d;
            proto_err_q    <= proto_err_d;
            finished_q     <= finished_d;
        end
    end

`ifdef NODF_MONITOR_MINMAX_EN
    logic [CNT_W-1:0] min_latency_q, min_latency_d;
    logic [CNT_W-1:0] max_latency_q, max_latency_d;

    always_comb begin
        min_latency_d = min_latency_q;
        max_latency_d = max_latency_q;
        if (complete_c) begin
            if (lat_done_c < min_latency_q) begin
                min_latency_d = lat_done_c;
            end
            if (lat_done_c > max_latency_q) begin
                max_latency_d = lat_done_c;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            min_latency_q <= CNT_MAX;
            max_latency_q <= '0;
        end else begin
            min_latency_q <= min_latency_d;
            max_latency_q <= max_latency_d;
        end
    end

    assign min_latency = min_latency_q;
    assign max_latency = max_latency_q;
`endif

    assign state        = state_q;
    assign last_latency = last_latency_q;
    assign sample_valid = sample_valid_q;
    assign proto_err    = proto_err_q;
    assign finished     = finished_q;

endmodule

// File: tb/tb_nodf_module_intf.sv
// tb_nodf_module_intf: vector table through a scoreboard queue, then
// hand-written saturation and min/max sequences (CNT_W reduced to 4).
module tb_nodf_module_intf;

    localparam int unsigned CW = 4;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic          ap_start = 1'b0;
    logic          ap_ready = 1'b0;
    logic          ap_done = 1'b0;
    logic          ap_continue = 1'b1;
    logic          finish = 1'b0;
    logic [1:0]    state;
    logic [CW-1:0] txn_count;
    logic [CW-1:0] last_latency;
    logic [CW-1:0] stall_cycles;
    logic          sample_valid;
    logic          proto_err;
    logic          finished;
`ifdef NODF_MONITOR_MINMAX_EN
    logic [CW-1:0] min_latency;
    logic [CW-1:0] max_latency;
`endif

    int total = 0;
    int bad   = 0;

    nodf_module_intf #(.CNT_W(CW)) dut (
        .clock        (clock),
        .reset        (rst_n),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_continue  (ap_continue),
        .finish       (finish),
        .state        (state),
        .txn_count    (txn_count),
        .last_latency (last_latency),
        .stall_cycles (stall_cycles),
        .sample_valid (sample_valid),
        .proto_err    (proto_err),
`ifdef NODF_MONITOR_MINMAX_EN
        .min_latency  (min_latency),
        .max_latency  (max_latency),
`endif
        .finished     (finished)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]    in;      // {rst_n, start, ready, done, cont, finish}
        logic [1:0]    st;
        logic [CW-1:0] txn;
        logic [CW-1:0] lat;
        logic [CW-1:0] stall;
        logic [2:0]    flags;   // {sample_valid, proto_err, finished}
        logic          sv_dc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];

    function automatic vec_t mk(input logic [5:0] in, input logic [1:0] st, input int txn,
                                input int lat, input int stall, input logic [2:0] flags,
                                input logic sv_dc);
        vec_t v;
        v.in    = in;
        v.st    = st;
        v.txn   = CW'(txn);
        v.lat   = CW'(lat);
        v.stall = CW'(stall);
        v.flags = flags;
        v.sv_dc = sv_dc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        rst_n = 1'b1; ap_start = 1'b0; ap_ready = 1'b0;
        ap_done = 1'b0; ap_continue = 1'b1; finish = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        {rst_n, ap_start, ap_ready, ap_done, ap_continue, finish} = v.in;
    endtask

    task automatic compare(input vec_t e, input int i);
        chk($sformatf("r%0d state", i), 32'(state), 32'(e.st));
        chk($sformatf("r%0d txn_count", i), 32'(txn_count), 32'(e.txn));
        chk($sformatf("r%0d last_latency", i), 32'(last_latency), 32'(e.lat));
        chk($sformatf("r%0d stall_cycles", i), 32'(stall_cycles), 32'(e.stall));
        if (!e.sv_dc) begin
            chk($sformatf("r%0d sample_valid", i), 32'(sample_valid), 32'(e.flags[2]));
        end
        chk($sformatf("r%0d proto_err", i), 32'(proto_err), 32'(e.flags[1]));
        chk($sformatf("r%0d finished", i), 32'(finished), 32'(e.flags[0]));
    endtask

    // n-cycle transaction: start in the first cycle, done&continue in the last.
    task automatic run_txn(input int n);
        ap_start = 1'b1; ap_continue = 1'b1; ap_done = (n == 1);
        step();
        ap_start = 1'b0;
        for (int k = 1; k < n; k++) begin
            ap_done = (k == n - 1);
            step();
        end
        ap_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // reset, then start with done&continue four cycles later
        vecs.push_back(mk(6'b000000, 0, 0, 0, 0, 3'b000, 0));
        vecs.push_back(mk(6'b110010, 1, 0, 0, 0, 3'b000, 0));
        vecs.push_back(mk(6'b100010, 1, 0, 0, 0, 3'b000, 0));
        vecs.push_back(mk(6'b100010, 1, 0, 0, 0, 3'b000, 0));
        vecs.push_back(mk(6'b100010, 1, 0, 0, 0, 3'b000, 0));
        vecs.push_back(mk(6'b100110, 0, 1, 5, 0, 3'b100, 0));
        vecs.push_back(mk(6'b100010, 0, 1, 5, 0, 3'b000, 0));
        // done stalled by continue for three cycles
        vecs.push_back(mk(6'b110000, 1, 1, 5, 0, 3'b000, 0));
        vecs.push_back(mk(6'b100100, 2, 1, 5, 1, 3'b000, 0));
        vecs.push_back(mk(6'b100100, 2, 1, 5, 2, 3'b000, 0));
        vecs.push_back(mk(6'b100100, 2, 1, 5, 3, 3'b000, 0));
        vecs.push_back(mk(6'b100110, 0, 2, 5, 3, 3'b100, 0));
        vecs.push_back(mk(6'b100010, 0, 2, 5, 3, 3'b000, 0));
        // three single-cycle transactions in a row
        vecs.push_back(mk(6'b110110, 0, 3, 1, 3, 3'b100, 0));
        vecs.push_back(mk(6'b110110, 0, 4, 1, 3, 3'b100, 0));
        vecs.push_back(mk(6'b110110, 0, 5, 1, 3, 3'b100, 0));
        vecs.push_back(mk(6'b100010, 0, 5, 1, 3, 3'b000, 0));
        // back-to-back two-cycle transactions
        vecs.push_back(mk(6'b110010, 1, 5, 1, 3, 3'b000, 0));
        vecs.push_back(mk(6'b100110, 0, 6, 2, 3, 3'b100, 0));
        vecs.push_back(mk(6'b110010, 1, 6, 2, 3, 3'b000, 0));
        vecs.push_back(mk(6'b100110, 0, 7, 2, 3, 3'b100, 0));
        vecs.push_back(mk(6'b100010, 0, 7, 2, 3, 3'b000, 0));
        // done in IDLE without start
        vecs.push_back(mk(6'b100110, 0, 7, 2, 3, 3'b010, 0));
        vecs.push_back(mk(6'b100010, 0, 7, 2, 3, 3'b010, 0));
        // finish mid-BUSY, later activity ignored, reset clears
        vecs.push_back(mk(6'b110010, 1, 7, 2, 3, 3'b010, 0));
        vecs.push_back(mk(6'b100010, 1, 7, 2, 3, 3'b010, 0));
        vecs.push_back(mk(6'b100011, 3, 7, 2, 3, 3'b011, 0));
        vecs.push_back(mk(6'b110110, 3, 7, 2, 3, 3'b011, 0));
        vecs.push_back(mk(6'b110110, 3, 7, 2, 3, 3'b011, 0));
        vecs.push_back(mk(6'b100100, 3, 7, 2, 3, 3'b011, 0));
        vecs.push_back(mk(6'b010010, 0, 0, 0, 0, 3'b000, 0));
        vecs.push_back(mk(6'b100010, 0, 0, 0, 0, 3'b000, 0));
        // done withdrawn in DONE_WAIT
        vecs.push_back(mk(6'b110000, 1, 0, 0, 0, 3'b000, 0));
        vecs.push_back(mk(6'b100100, 2, 0, 0, 1, 3'b000, 0));
        vecs.push_back(mk(6'b100000, 0, 0, 0, 1, 3'b010, 0));
        // ready in IDLE without start
        vecs.push_back(mk(6'b000010, 0, 0, 0, 0, 3'b000, 0));
        vecs.push_back(mk(6'b101010, 0, 0, 0, 0, 3'b010, 0));
        // reset mid-transaction beats a completion
        vecs.push_back(mk(6'b110010, 1, 0, 0, 0, 3'b010, 0));
        vecs.push_back(mk(6'b000110, 0, 0, 0, 0, 3'b000, 0));
        vecs.push_back(mk(6'b100010, 0, 0, 0, 0, 3'b000, 0));
        // completion coinciding with finish is counted
        vecs.push_back(mk(6'b110010, 1, 0, 0, 0, 3'b000, 0));
        vecs.push_back(mk(6'b100111, 3, 1, 2, 0, 3'b001, 1));
        vecs.push_back(mk(6'b100010, 3, 1, 2, 0, 3'b001, 0));
        vecs.push_back(mk(6'b000010, 0, 0, 0, 0, 3'b000, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t e;
            drive(vecs[i]);
            sb_q.push_back(vecs[i]);
            step();
            e = sb_q.pop_front();
            compare(e, i);
        end

        // latency counter saturates on a 20-cycle transaction
        idle_in();
        run_txn(20);
        chk("sat last_latency", 32'(last_latency), 32'd15);
        chk("sat txn_count", 32'(txn_count), 32'd1);
        chk("sat sample_valid", 32'(sample_valid), 32'd1);
        step();
        chk("sat sample_valid drop", 32'(sample_valid), 32'd0);

        // transaction counter saturates
        ap_start = 1'b1; ap_done = 1'b1; ap_continue = 1'b1;
        repeat (20) step();
        idle_in();
        chk("txn saturate", 32'(txn_count), 32'd15);
        chk("txn sat latency", 32'(last_latency), 32'd1);
        chk("txn sat state", 32'(state), 32'd0);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("reset2 txn_count", 32'(txn_count), 32'd0);
        chk("reset2 last_latency", 32'(last_latency), 32'd0);
`ifdef NODF_MONITOR_MINMAX_EN
        chk("reset min_latency", 32'(min_latency), 32'hF);
        chk("reset max_latency", 32'(max_latency), 32'd0);
        run_txn(5);
        run_txn(2);
        run_txn(9);
        chk("minmax min_latency", 32'(min_latency), 32'd2);
        chk("minmax max_latency", 32'(max_latency), 32'd9);
        chk("minmax txn_count", 32'(txn_count), 32'd3);
        chk("minmax last_latency", 32'(last_latency), 32'd9);
`else
        run_txn(3);
        chk("post reset last_latency", 32'(last_latency), 32'd3);
        chk("post reset txn_count", 32'(txn_count), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nodf_module_intf.md
# nodf_module_intf

Synthesizable status monitor for one non-dataflow HLS block. It observes the block-level handshake (`ap_start`, `ap_ready`, `ap_done`, `ap_continue`) plus a simulation-wide `finish` strobe, and tracks per-transaction state, count and latency. Its registered counters feed the sample manager and CSV status dump in the dataflow monitor top. It is strictly passive: it never drives the observed block.

## Interface
- `CNT_W`, default 32: width of all counters; counters saturate at all-ones.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `ap_start` in 1: observed start request.
- `ap_ready` in 1: observed input-accepted pulse.
- `ap_done` in 1: observed completion.
- `ap_continue` in 1: observed downstream acknowledge (tie 1 when absent).
- `finish` in 1: end-of-run strobe; freezes the monitor.
- `state` out 2: 0 IDLE, 1 BUSY, 2 DONE_WAIT, 3 FINISHED.
- `txn_count` out CNT_W: completed transactions.
- `last_latency` out CNT_W: cycles of the most recent transaction.
- `stall_cycles` out CNT_W: total cycles with `ap_done`=1 and `ap_continue`=0.
- `sample_valid` out 1: one-cycle pulse when `txn_count`/`last_latency` update.
- `proto_err` out 1: sticky protocol-violation flag.
- `finished` out 1: sticky, set by `finish`.

## Operation
- A transaction completes in any cycle with `ap_done`=1 and `ap_continue`=1, in state BUSY or DONE_WAIT.
- IDLE: on `ap_start`=1, clear the latency counter to 1.
  - If `ap_done`&`ap_continue` in the same cycle, complete with latency 1 and stay IDLE.
  - Otherwise go to BUSY.
- BUSY: increment the latency counter each cycle.
  - On `ap_done`&`ap_continue`: complete and go to IDLE.
  - On `ap_done`&!`ap_continue`: go to DONE_WAIT.
- DONE_WAIT: increment the latency counter and `stall_cycles` each cycle.
  - On `ap_continue`=1: complete and go to IDLE.
  - If `ap_done` drops without `ap_continue`: set `proto_err` and go to IDLE; nothing is counted.
- Completion:
  - `txn_count` += 1.
  - `last_latency` = latency counter value including the done cycle.
  - Pulse `sample_valid`.
- Latency definition: cycles from the start cycle through the done cycle, inclusive.
- `ap_ready` is informational only. `ap_ready`=1 in IDLE while `ap_start`=0 sets `proto_err`.
- `ap_done`=1 in IDLE while `ap_start`=0 sets `proto_err`; nothing is counted.
- `finish`=1 in any state:
  - Next state is FINISHED, `finished`=1.
  - All counters freeze and `sample_valid` stays 0.
  - Only `reset` leaves FINISHED.
  - A completion in the same cycle as `finish` is still counted.
- All counters saturate at 2^CNT_W−1; no wrap.

## Timing
- All outputs are registered and update on the clock edge after the sampled event (1-cycle latency).
- Reset values: `state`=IDLE and every counter and flag = 0.
- Reset wins over every other input in the same cycle, including mid-transaction; the in-flight transaction is discarded.
- Back-to-back transactions: `ap_start` in the cycle right after a completion starts a new transaction with no idle gap required.
- `sample_valid` is high for exactly one cycle per completion.

## Configuration
- `NODF_MONITOR_MINMAX_EN` defined:
  - Adds outputs `min_latency` and `max_latency` (CNT_W each), updated on every completion.
  - Reset values: `min_latency` = all-ones, `max_latency` = 0.
- Undefined: those ports and registers do not exist.

## Structure
- Shared package `nodf_mon_pkg` holds:
  - the state enum (IDLE/BUSY/DONE_WAIT/FINISHED, 2-bit);
  - a `SAT_MAX` function for CNT_W-wide saturation.
- One natural sub-module: `sat_counter`, a CNT_W saturating counter with synchronous clear and enable. It is used for the latency, txn and stall counters.

## Test plan
- Start at cycle 0, `ap_done`&`ap_continue` at cycle 4 -> one cycle later `txn_count`=1, `last_latency`=5, `sample_valid` pulses once, `state`=IDLE.
- `ap_done`=1 with `ap_continue`=0 for 3 cycles, then `ap_continue`=1 -> `stall_cycles`=3, `txn_count` increments once, `state` passes through DONE_WAIT.
- `ap_start`, `ap_done` and `ap_continue` high together for 3 consecutive cycles -> `txn_count`=3, `last_latency`=1, `state` stays IDLE.
- `ap_done`=1 in IDLE with `ap_start`=0 -> `proto_err`=1 (sticky), `txn_count` unchanged.
- `finish`=1 mid-BUSY, then further transactions -> `state`=FINISHED, `finished`=1, counters frozen. Asserting `reset`=0 for one cycle returns all outputs to 0.
- With `NODF_MONITOR_MINMAX_EN`, latencies 5, 2, 9 -> `min_latency`=2, `max_latency`=9.
